// File: rtl/div_unit_param.sv
// div_unit_param: multi-cycle restoring divider, STEP_BITS quotient bits per cycle.
// Result is {remainder, quotient}; signed/unsigned, annul and divide-by-zero paths.
module div_unit_param #(
  parameter int WIDTH     = 32,
  parameter int STEP_BITS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] STEP = CW'(STEP_BITS);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - STEP_BITS);

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BYZERO = 2'b01,
    ON     = 2'b10,
    END    = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               sgn1_q, sgn1_d;
  logic               sgn2_q, sgn2_d;
  logic               mode_q, mode_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH-1:0]   step_rem, step_quo;
  logic [WIDTH-1:0]   quo_fin, rem_fin;
  logic               neg1, neg2;

  // Operand magnitudes; an unsigned WIDTH-bit view holds |MIN| exactly.
  always_comb begin
    neg1 = signed_div_i & opdata1_i[WIDTH-1];
    neg2 = signed_div_i & opdata2_i[WIDTH-1];
    mag1 = neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
    mag2 = neg2 ? (~opdata2_i + 1'b1) : opdata2_i;
  end

  // STEP_BITS chained restoring iterations; dvd shifts dividend out, quotient in.
  always_comb begin : step_chain
    logic [WIDTH-1:0] rem_v;
    logic [WIDTH-1:0] quo_v;
    logic [WIDTH:0]   sh_v;
    logic [WIDTH:0]   diff_v;
    rem_v  = rem_q;
    quo_v  = dvd_q;
    sh_v   = '0;
    diff_v = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      sh_v   = {rem_v, quo_v[WIDTH-1]};
      diff_v = sh_v - {1'b0, dvs_q};
      quo_v  = {quo_v[WIDTH-2:0], ~diff_v[WIDTH]};
      rem_v  = diff_v[WIDTH] ? sh_v[WIDTH-1:0] : diff_v[WIDTH-1:0];
    end
    step_rem = rem_v;
    step_quo = quo_v;
  end

  // Sign fix-up of the final iteration's magnitudes.
  always_comb begin
    quo_fin = step_quo;
    rem_fin = step_rem;
    if (mode_q && (sgn1_q ^ sgn2_q)) quo_fin = ~step_quo + 1'b1;
    if (mode_q && sgn1_q)            rem_fin = ~step_rem + 1'b1;
  end

  // Next-state and datapath update; annul beats start everywhere.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    sgn1_d   = sgn1_q;
    sgn2_d   = sgn2_q;
    mode_d   = mode_q;
    result_d = result_q;
    ready_d  = ready_q;
    unique case (state_q)
      FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = BYZERO;
          end else begin
            state_d = ON;
            dvd_d   = mag1;
            dvs_d   = mag2;
            sgn1_d  = opdata1_i[WIDTH-1];
            sgn2_d  = opdata2_i[WIDTH-1];
            mode_d  = signed_div_i;
            cnt_d   = '0;
            rem_d   = '0;
          end
        end
      end
      BYZERO: begin
        result_d = '0;
        if (annul_i) begin
          state_d = FREE;
          ready_d = 1'b0;
        end else begin
          state_d = END;
          ready_d = 1'b1;
        end
      end
      ON: begin
        if (annul_i) begin
          state_d  = FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end else begin
          dvd_d = step_quo;
          rem_d = step_rem;
          cnt_d = cnt_q + STEP;
          if (cnt_q == LAST) begin
            state_d  = END;
            result_d = {rem_fin, quo_fin};
            ready_d  = 1'b1;
          end
        end
      end
      END: begin
        if (annul_i || !start_i) begin
          state_d  = FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        state_d  = FREE;
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      sgn1_q   <= 1'b0;
      sgn2_q   <= 1'b0;
      mode_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      sgn1_q   <= sgn1_d;
      sgn2_q   <= sgn2_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit_param.sv
// tb_div_unit_param: three divider instances (32/1, 32/4, 16/2) on one request stream.
// Stimulus pushes expected {result, latency}; a negedge monitor pops and compares.
module tb_div_unit_param;

  logic        clk;
  logic        rst;
  logic        start;
  logic        annul;
  logic        sgn;
  logic [31:0] opa1, opa2;
  logic [15:0] opc1, opc2;
  logic [63:0] res_a, res_b;
  logic [31:0] res_c;
  logic        rdy_a, rdy_b, rdy_c;

  div_unit_param #(.WIDTH(32), .STEP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .start_i(start), .annul_i(annul),
    .signed_div_i(sgn), .opdata1_i(opa1), .opdata2_i(opa2),
    .result_o(res_a), .ready_o(rdy_a)
  );

  div_unit_param #(.WIDTH(32), .STEP_BITS(4)) u_b (
    .clk(clk), .rst(rst), .start_i(start), .annul_i(annul),
    .signed_div_i(sgn), .opdata1_i(opa1), .opdata2_i(opa2),
    .result_o(res_b), .ready_o(rdy_b)
  );

  div_unit_param #(.WIDTH(16), .STEP_BITS(2)) u_c (
    .clk(clk), .rst(rst), .start_i(start), .annul_i(annul),
    .signed_div_i(sgn), .opdata1_i(opc1), .opdata2_i(opc2),
    .result_o(res_c), .ready_o(rdy_c)
  );

  typedef struct {
    logic [63:0] r;
    int          lat;
  } exp_t;

  exp_t        qa[$], qb[$], qc[$];
  logic [63:0] res [3];
  logic        rdy [3];
  logic [63:0] held [3];
  bit          prev [3] = '{0, 0, 0};
  int          checks = 0;
  int          passes = 0;
  int          rises = 0;
  int          cyc = 0;
  int          issue = 0;

  assign res[0] = res_a;
  assign res[1] = res_b;
  assign res[2] = {32'd0, res_c};
  assign rdy[0] = rdy_a;
  assign rdy[1] = rdy_b;
  assign rdy[2] = rdy_c;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input bit ok,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: plain integer division on sign-extended values of width w.
  function automatic logic [63:0] ref_div(input int w, input bit sg,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint m, x, y, q, r;
    m = (longint'(1) << w) - 1;
    x = longint'(a) & m;
    y = longint'(b) & m;
    if (y == 0) return 64'd0;
    if (sg) begin
      if (((x >> (w - 1)) & 1) != 0) x = x - (longint'(1) << w);
      if (((y >> (w - 1)) & 1) != 0) y = y - (longint'(1) << w);
    end
    q = x / y;
    r = x % y;
    return 64'(((r & m) << w) | (q & m));
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 9))
      0: return 16'd0;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'd1;
      4: return 16'($urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor: compare on each ready rise, watch holds and drops.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rdy[k] && !prev[k]) begin
        exp_t e;
        bit   have;
        rises++;
        have = 1'b0;
        e = '{64'd0, 0};
        case (k)
          0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
          1: if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
          default:
            if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
          chk($sformatf("unexpected_ready[%0d]", k), 1'b0, res[k], 64'd0);
        end else begin
          chk($sformatf("result[%0d]", k), res[k] == e.r, res[k], e.r);
          chk($sformatf("latency[%0d]", k), (cyc - issue + 1) == e.lat,
              64'(cyc - issue + 1), 64'(e.lat));
        end
        held[k] = res[k];
      end else if (rdy[k] && prev[k]) begin
        chk($sformatf("hold[%0d]", k), res[k] == held[k], res[k], held[k]);
      end else if (!rdy[k] && prev[k]) begin
        chk($sformatf("drop_zero[%0d]", k), res[k] == 64'd0, res[k], 64'd0);
      end
      prev[k] = rdy[k];
    end
  end

  task automatic all_idle(input string nm);
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s[%0d]", nm, k), !rdy[k] && res[k] == 64'd0,
          {rdy[k], res[k][62:0]}, 64'd0);
  endtask

  task automatic do_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                        input logic [15:0] c1, input logic [15:0] c2,
                        input int hold, input bit kill);
    int n;
    @(negedge clk);
    sgn   = s;
    opa1  = a;
    opa2  = b;
    opc1  = c1;
    opc2  = c2;
    start = 1'b1;
    issue = cyc + 1;
    qa.push_back('{ref_div(32, s, a, b), (b == 0) ? 2 : 33});
    qb.push_back('{ref_div(32, s, a, b), (b == 0) ? 2 : 9});
    qc.push_back('{ref_div(16, s, {16'd0, c1}, {16'd0, c2}), (c2 == 0) ? 2 : 9});
    n = 0;
    while (!(rdy_a && rdy_b && rdy_c) && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        sgn  = $urandom_range(0, 1) == 1;
        opa1 = $urandom;
        opa2 = $urandom;
        opc1 = 16'($urandom);
        opc2 = 16'($urandom);
      end
    end
    if (n >= 100) chk("ready_timeout", 1'b0, 64'(n), 64'd100);
    repeat (hold) @(negedge clk);
    if (kill) annul = 1'b1;
    else start = 1'b0;
    @(posedge clk);
    #1;
    all_idle(kill ? "end_annul" : "end_drop");
    @(negedge clk);
    annul = 1'b0;
    start = 1'b0;
  endtask

  task automatic annul_run(input logic [31:0] b, input logic [15:0] c2,
                           input int after, input bit hold_start);
    int r0;
    @(negedge clk);
    r0    = rises;
    sgn   = 1'b0;
    opa1  = 32'hFFFF_FFFF;
    opa2  = b;
    opc1  = 16'hFFFF;
    opc2  = c2;
    start = 1'b1;
    annul = hold_start;
    repeat (after) @(negedge clk);
    annul = 1'b1;
    start = hold_start;
    @(negedge clk);
    annul = 1'b0;
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("annul_no_ready", rises == r0, 64'(rises), 64'(r0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    annul = 1'b0;
    sgn   = 1'b0;
    opa1  = '0;
    opa2  = '0;
    opc1  = '0;
    opc2  = '0;
    #1;
    all_idle("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_div(1'b0, 32'd100, 32'd7, 16'd100, 16'd7, 5, 1'b0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 16'hFFF9, 16'd2, 1, 1'b0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 16'd7, 16'hFFFE, 0, 1'b0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 16'h8000, 16'hFFFF, 0, 1'b0);
    do_div(1'b0, 32'd1234, 32'd0, 16'd1234, 16'd0, 2, 1'b0);
    do_div(1'b1, 32'd1234, 32'd0, 16'd1234, 16'd0, 0, 1'b0);
    do_div(1'b0, 32'd1000000, 32'd999, 16'd50000, 16'd7, 0, 1'b0);

    annul_run(32'd3, 16'd3, 6, 1'b0);
    annul_run(32'd0, 16'd0, 1, 1'b0);
    annul_run(32'd3, 16'd3, 3, 1'b1);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd3, 16'hFFFF, 16'd3, 0, 1'b0);
    do_div(1'b1, 32'hFFFF_FF00, 32'd9, 16'hFF00, 16'd9, 2, 1'b1);

    @(negedge clk);
    sgn   = 1'b0;
    opa1  = 32'd123456789;
    opa2  = 32'd1000;
    opc1  = 16'd5000;
    opc2  = 16'd7;
    start = 1'b1;
    issue = cyc + 1;
    qb.push_back('{ref_div(32, 1'b0, 32'd123456789, 32'd1000), 9});
    qc.push_back('{ref_div(16, 1'b0, 32'd5000, 32'd7), 9});
    repeat (12) @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    all_idle("async_reset");
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_div(1'b0, 32'd9, 32'd3, 16'd9, 16'd3, 0, 1'b0);

    for (int i = 0; i < 1000; i++)
      do_div($urandom_range(0, 1) == 1, rnd32(), rnd32(), rnd16(), rnd16(),
             $urandom_range(0, 2), $urandom_range(0, 19) == 0);

    repeat (5) @(negedge clk);
    chk("queues_drained", qa.size() + qb.size() + qc.size() == 0,
        64'(qa.size() + qb.size() + qc.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
